// File: rtl/v_issue_pkg.sv
// Shared definitions for the vector issue path: opcode constants and the queue entry layout.
// No logic of its own; the classification helpers are purely combinational.
// Backpressure is not applicable here.
package v_issue_pkg;

  // Width of the instruction word and of each scalar operand carried in an entry.
  localparam int V_XLEN = 32;

  // Major opcodes, taken from instr[6:0], that identify vector memory operations.
  localparam logic [6:0] OPC_VLOAD  = 7'b0000111;
  localparam logic [6:0] OPC_VSTORE = 7'b0100111;

  // One queued vector instruction together with the scalar operands read alongside it.
  typedef struct packed {
    logic [V_XLEN-1:0] instr;
    logic [V_XLEN-1:0] rs1;
    logic [V_XLEN-1:0] rs2;
  } v_issue_entry_t;

  function automatic logic is_vload(input logic [V_XLEN-1:0] instr);
    return instr[6:0] == OPC_VLOAD;
  endfunction

  function automatic logic is_vstore(input logic [V_XLEN-1:0] instr);
    return instr[6:0] == OPC_VSTORE;
  endfunction

endpackage

// File: rtl/v_outstanding_cnt.sv
// Counts outstanding vector memory operations: +1 per issue, -1 per completion, never wraps.
// Latency: one cycle from inc/dec to the updated count, zero and max flags.
// Backpressure: none internally; the owner stops issuing while max_o is high.
module v_outstanding_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o,
  output logic             max_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inc_ok, dec_ok;

  // A completion with nothing outstanding is spurious and is dropped; an issue at max is
  // blocked by the owner's stall, and is also gated here so the counter can never wrap.
  always_comb begin
    dec_ok = dec_i & (cnt_q != '0);
    inc_ok = inc_i & (cnt_q != '1);
    cnt_d  = cnt_q;
    if (inc_ok && !dec_ok) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (dec_ok && !inc_ok) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
  assign max_o  = (cnt_q == '1);

endmodule

// File: rtl/v_issue_queue.sv
// Buffers vector instructions plus scalar operands from scalar_core and issues them in order to vector_core.
// Latency: a push is visible at the head the next cycle; minimum push-to-pop is one cycle.
// Backpressure: stall when full or when either outstanding load/store counter is saturated; no pop-to-push bypass.
module v_issue_queue
  import v_issue_pkg::*;
#(
  parameter int XLEN  = V_XLEN,
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            v_instr_valid_i,
  input  logic [XLEN-1:0] v_instruction_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            vector_stall_o,
  output logic            all_v_loads_executed_o,
  output logic            all_v_stores_executed_o,
  output logic            overflow_o,
  output logic            vec_valid_o,
  input  logic            vec_ready_i,
  output logic [XLEN-1:0] vec_instr_o,
  output logic [XLEN-1:0] vec_rs1_o,
  output logic [XLEN-1:0] vec_rs2_o,
  input  logic            v_load_done_i,
  input  logic            v_store_done_i
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  v_issue_entry_t   mem_q [DEPTH];
  v_issue_entry_t   head_entry;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             push, pop, push_ld, push_st;
  logic             ld_zero, ld_max, st_zero, st_max;
  logic [CNT_W-1:0] ld_cnt, st_cnt;

  // Stall looks only at registered state so the scalar core sees a clean, early signal.
  assign vector_stall_o = (count_q == FULL_CNT) | ld_max | st_max;
  assign vec_valid_o    = (count_q != '0);
  assign push           = v_instr_valid_i & ~vector_stall_o;
  assign pop            = vec_valid_o & vec_ready_i;
  assign push_ld        = push & is_vload(v_instruction_i);
  assign push_st        = push & is_vstore(v_instruction_i);

  // Pointer, occupancy and sticky-overflow next state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (v_instr_valid_i & vector_stall_o);
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous reset; a push or pop during reset is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; contents are don't-care until the slot is counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{instr: v_instruction_i, rs1: rs1_i, rs2: rs2_i};
    end
  end

  // Head entry is read straight from the array, so it holds steady while the consumer stalls.
  assign head_entry  = mem_q[rd_ptr_q];
  assign vec_instr_o = head_entry.instr;
  assign vec_rs1_o   = head_entry.rs1;
  assign vec_rs2_o   = head_entry.rs2;
  assign overflow_o  = overflow_q;

  // Loads are counted from issue into the queue until the vector core reports completion.
  v_outstanding_cnt #(.CNT_W(CNT_W)) u_ld_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc_i  (push_ld),
    .dec_i  (v_load_done_i),
    .cnt_o  (ld_cnt),
    .zero_o (ld_zero),
    .max_o  (ld_max)
  );

  // Stores follow the same rule as loads.
  v_outstanding_cnt #(.CNT_W(CNT_W)) u_st_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc_i  (push_st),
    .dec_i  (v_store_done_i),
    .cnt_o  (st_cnt),
    .zero_o (st_zero),
    .max_o  (st_max)
  );

  assign all_v_loads_executed_o  = ld_zero;
  assign all_v_stores_executed_o = st_zero;

endmodule

// File: tb/tb_v_issue_queue.sv
// Directed bench for v_issue_queue: fill/drain, load/store tracking, overflow, wrap and saturation.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// Expected values are hand-derived constants for each step.
module tb_v_issue_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        v_instr_valid_i;
  logic [31:0] v_instruction_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        vector_stall_o;
  logic        all_v_loads_executed_o;
  logic        all_v_stores_executed_o;
  logic        overflow_o;
  logic        vec_valid_o;
  logic        vec_ready_i;
  logic [31:0] vec_instr_o;
  logic [31:0] vec_rs1_o;
  logic [31:0] vec_rs2_o;
  logic        v_load_done_i;
  logic        v_store_done_i;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] ARITH = 32'h0000_0057;
  localparam logic [31:0] VLD   = 32'h0200_0007;
  localparam logic [31:0] VST   = 32'h0000_0027;

  always #5 clk = ~clk;

  v_issue_queue #(.XLEN(32), .DEPTH(4), .CNT_W(4)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .v_instr_valid_i         (v_instr_valid_i),
    .v_instruction_i         (v_instruction_i),
    .rs1_i                   (rs1_i),
    .rs2_i                   (rs2_i),
    .vector_stall_o          (vector_stall_o),
    .all_v_loads_executed_o  (all_v_loads_executed_o),
    .all_v_stores_executed_o (all_v_stores_executed_o),
    .overflow_o              (overflow_o),
    .vec_valid_o             (vec_valid_o),
    .vec_ready_i             (vec_ready_i),
    .vec_instr_o             (vec_instr_o),
    .vec_rs1_o               (vec_rs1_o),
    .vec_rs2_o               (vec_rs2_o),
    .v_load_done_i           (v_load_done_i),
    .v_store_done_i          (v_store_done_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [31:0] instr, input logic [31:0] r1);
    v_instr_valid_i = vld;
    v_instruction_i = instr;
    rs1_i           = r1;
    rs2_i           = r1 + 32'h100;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    vec_ready_i    = 1'b0;
    v_load_done_i  = 1'b0;
    v_store_done_i = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Idle after reset
    check("rst_valid", 32'(vec_valid_o), 32'd0);
    check("rst_stall", 32'(vector_stall_o), 32'd0);
    check("rst_all_ld", 32'(all_v_loads_executed_o), 32'd1);
    check("rst_all_st", 32'(all_v_stores_executed_o), 32'd1);
    check("rst_ovf", 32'(overflow_o), 32'd0);

    // Fill with four arithmetic instructions while the consumer is not ready
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, ARITH, 32'(i));
      tick();
      check("fill_valid", 32'(vec_valid_o), 32'd1);
      check("fill_head_rs1", vec_rs1_o, 32'd1);
      check("fill_stall", 32'(vector_stall_o), (i == 4) ? 32'd1 : 32'd0);
    end

    // Push while full: dropped, overflow set
    drive(1'b1, 32'h0000_0099, 32'd99);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("ovf_set", 32'(overflow_o), 32'd1);
    check("ovf_still_full", 32'(vector_stall_o), 32'd1);
    check("ovf_all_ld", 32'(all_v_loads_executed_o), 32'd1);

    // Drain in order, one per cycle
    vec_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_valid", 32'(vec_valid_o), 32'd1);
      check("drain_instr", vec_instr_o, ARITH);
      check("drain_rs1", vec_rs1_o, 32'(i));
      check("drain_rs2", vec_rs2_o, 32'(i) + 32'h100);
      tick();
      check("drain_stall", 32'(vector_stall_o), 32'd0);
    end
    check("drain_empty", 32'(vec_valid_o), 32'd0);
    check("ovf_sticky", 32'(overflow_o), 32'd1);
    vec_ready_i = 1'b0;

    // Single load: tracked from push until done pulse
    drive(1'b1, VLD, 32'd7);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("ld_pending", 32'(all_v_loads_executed_o), 32'd0);
    check("ld_st_idle", 32'(all_v_stores_executed_o), 32'd1);
    check("ld_head", vec_instr_o, VLD);
    vec_ready_i = 1'b1;
    tick();
    vec_ready_i = 1'b0;
    check("ld_popped", 32'(vec_valid_o), 32'd0);
    check("ld_inflight", 32'(all_v_loads_executed_o), 32'd0);
    v_load_done_i = 1'b1;
    tick();
    v_load_done_i = 1'b0;
    check("ld_done", 32'(all_v_loads_executed_o), 32'd1);

    // Simultaneous load push and load done at ld_cnt==1
    drive(1'b1, VLD, 32'd8);
    tick();
    drive(1'b1, VLD, 32'd9);
    v_load_done_i = 1'b1;
    vec_ready_i   = 1'b1;
    tick();
    drive(1'b0, 32'h0, 32'h0);
    v_load_done_i = 1'b0;
    check("ldsim_pending", 32'(all_v_loads_executed_o), 32'd0);
    check("ldsim_head", vec_rs1_o, 32'd9);
    tick();
    vec_ready_i = 1'b0;
    check("ldsim_empty", 32'(vec_valid_o), 32'd0);
    check("ldsim_still", 32'(all_v_loads_executed_o), 32'd0);
    v_load_done_i = 1'b1;
    tick();
    check("ldsim_one_left", 32'(all_v_loads_executed_o), 32'd1);
    // Extra done pulse at zero must not underflow
    tick();
    v_load_done_i = 1'b0;
    tick();
    check("ld_no_underflow", 32'(all_v_loads_executed_o), 32'd1);
    check("ld_no_underflow_stall", 32'(vector_stall_o), 32'd0);

    // Store tracking
    drive(1'b1, VST, 32'd5);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("st_pending", 32'(all_v_stores_executed_o), 32'd0);
    check("st_ld_idle", 32'(all_v_loads_executed_o), 32'd1);
    vec_ready_i = 1'b1;
    tick();
    vec_ready_i    = 1'b0;
    v_store_done_i = 1'b1;
    tick();
    v_store_done_i = 1'b0;
    check("st_done", 32'(all_v_stores_executed_o), 32'd1);

    // Push and pop every cycle across the pointer wrap
    vec_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, ARITH, 32'd100 + 32'(i));
      tick();
      check("wrap_head", vec_rs1_o, 32'd100 + 32'(i));
      check("wrap_stall", 32'(vector_stall_o), 32'd0);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("wrap_count_one", 32'(vec_valid_o), 32'd0);

    // Saturate the load counter: 15 outstanding loads raise the stall
    for (int i = 1; i <= 15; i++) begin
      drive(1'b1, VLD, 32'(i));
      tick();
      check("sat_stall", 32'(vector_stall_o), (i == 15) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("sat_drained", 32'(vec_valid_o), 32'd0);
    check("sat_hold", 32'(vector_stall_o), 32'd1);
    v_load_done_i = 1'b1;
    tick();
    v_load_done_i = 1'b0;
    check("sat_release", 32'(vector_stall_o), 32'd0);
    check("sat_ld_pending", 32'(all_v_loads_executed_o), 32'd0);
    vec_ready_i = 1'b0;

    // Reset mid-operation, with a push attempted in the reset cycle
    drive(1'b1, VST, 32'd3);
    tick();
    check("mid_valid", 32'(vec_valid_o), 32'd1);
    check("mid_st", 32'(all_v_stores_executed_o), 32'd0);
    reset = 1'b1;
    drive(1'b1, ARITH, 32'd4);
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("mid_rst_valid", 32'(vec_valid_o), 32'd0);
    check("mid_rst_ld", 32'(all_v_loads_executed_o), 32'd1);
    check("mid_rst_st", 32'(all_v_stores_executed_o), 32'd1);
    check("mid_rst_ovf", 32'(overflow_o), 32'd0);
    check("mid_rst_stall", 32'(vector_stall_o), 32'd0);
    tick();
    check("mid_rst_push_ignored", 32'(vec_valid_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/v_issue_queue.md
Name: v_issue_queue

Overview:
Buffered issue path between scalar_core and vector_core. It replaces the direct v_instruction/rs1/rs2 wiring and the hard-tied vector_stall.
- Queues vector instructions with their scalar operands.
- Hands them to the vector core over a valid/ready handshake.
- Tracks outstanding vector loads and stores, driving the scalar core's stall and all_v_*_executed inputs.

Parameters:
XLEN, 32, width of instruction word and of each scalar operand (rs1, rs2)
DEPTH, 4, queue entries; power of two, >= 2
CNT_W, 4, width of outstanding load/store counters

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
v_instr_valid_i  in  1  scalar core presents a vector instruction this cycle
v_instruction_i  in  XLEN  instruction word
rs1_i  in  XLEN  rs1 value captured with the instruction
rs2_i  in  XLEN  rs2 value captured with the instruction
vector_stall_o  out  1  scalar core must hold its vector instruction
all_v_loads_executed_o  out  1  no vector load is queued or in flight
all_v_stores_executed_o  out  1  no vector store is queued or in flight
overflow_o  out  1  sticky error: push attempted while stalled
vec_valid_o  out  1  head entry valid toward vector core
vec_ready_i  in  1  vector core accepts the head entry
vec_instr_o  out  XLEN  head instruction
vec_rs1_o  out  XLEN  head rs1
vec_rs2_o  out  XLEN  head rs2
v_load_done_i  in  1  pulse: one vector load completed
v_store_done_i  in  1  pulse: one vector store completed

Behaviour:
- Reset (synchronous, active-high):
  - wr/rd pointers and occupancy count = 0; ld_cnt = st_cnt = 0; overflow_o = 0.
  - Outputs after reset: vec_valid_o = 0, vector_stall_o = 0, all_v_*_executed_o = 1.
  - Reset mid-operation discards all entries and counters; a push or pop in the reset cycle is ignored.
- Classification, on the opcode field instr[6:0]:
  - 7'b0000111 = load (is_ld).
  - 7'b0100111 = store (is_st).
  - Anything else = arithmetic/config.
- Stall, combinational from registered state only:
  - vector_stall_o = (count == DEPTH) | (ld_cnt == max) | (st_cnt == max).
  - No dependence on vec_ready_i, so there is no pop-to-push bypass.
- Push: push = v_instr_valid_i & ~vector_stall_o.
  - Writes {instr, rs1, rs2} at wr_ptr; wr_ptr wraps modulo DEPTH.
  - v_instr_valid_i & vector_stall_o drops the entry and sets overflow_o; overflow_o clears only on reset.
- Pop: pop = vec_valid_o & vec_ready_i; rd_ptr advances and wraps modulo DEPTH.
- Outputs toward the vector core:
  - vec_valid_o = (count != 0).
  - vec_*_o are driven from the rd_ptr entry and stay stable while vec_valid_o & ~vec_ready_i.
- Latency: an entry pushed in cycle N is first visible at the head in cycle N+1 (empty queue); minimum push-to-pop is 1 cycle.
- count update: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
  - Simultaneous push and pop at full cannot occur, because push is blocked.
- ld_cnt update:
  - +1 on push & is_ld; −1 on v_load_done_i.
  - Simultaneous increment and decrement leaves it unchanged.
  - A done pulse at ld_cnt == 0 is ignored (no underflow).
- st_cnt: same rules using is_st and v_store_done_i.
- all_v_loads_executed_o = (ld_cnt == 0); all_v_stores_executed_o = (st_cnt == 0). Both are registered-state derived.
- Counter saturation at 2^CNT_W−1 raises the stall, so no counter ever wraps.

Decomposition:
- Package v_issue_pkg holds:
  - Opcode constants OPC_VLOAD = 7'b0000111 and OPC_VSTORE = 7'b0100111.
  - Typedef v_issue_entry_t {instr, rs1, rs2}, parametrised by XLEN through a localparam.
- Sub-module v_outstanding_cnt (inc, dec, CNT_W) → count, zero, max. It is instantiated twice, for loads and stores.
- Storage is an inline register array; no separate FIFO module.

Test Plan:
- Reset then idle → vec_valid_o=0, vector_stall_o=0, all_v_loads_executed_o=1, all_v_stores_executed_o=1, overflow_o=0.
- Push 4 arithmetic instrs (0x0000_0057, rs1=1..4) with vec_ready_i=0 → vector_stall_o=1 after the 4th push.
  - Then set vec_ready_i=1 → the 4 entries pop in order with matching rs1 values, one per cycle; stall drops the cycle after the first pop.
- Push a load (0x0200_0007) → all_v_loads_executed_o=0 from the next cycle.
  - After it pops and v_load_done_i is pulsed, all_v_loads_executed_o=1 the following cycle.
- Hold ld_cnt=1 while pushing a load and pulsing v_load_done_i in the same cycle → ld_cnt stays 1, all_v_loads_executed_o stays 0.
- Push with the queue full (vector_stall_o=1) → entry is not stored and overflow_o=1 until reset.
- Push and pop in the same cycle across the wrap (8 consecutive instrs, DEPTH=4, vec_ready_i=1) → in-order output, count never exceeds 1, no stall.
